// File: rtl/dvsd_mul_arb.sv
// ============================================================================
// Module   : dvsd_mul_arb
// Brief    : Two-port arbiter/sequencer for a shared 8x8->16 combinational
//            multiplier. Optional round-robin via DVSD_MUL_ARB_RR_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dvsd_mul_arb #(
    parameter int SETTLE_CYC = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    output logic        req1_ready,
    output logic        rsp0_valid,
    output logic [15:0] rsp0_m,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    output logic [15:0] rsp1_m,
    input  logic        rsp1_ready,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic [15:0] mul_m,
    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] C_CNT_INIT = 4'(SETTLE_CYC - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [7:0]  r_op_a;
    logic [7:0]  r_op_b;
    logic        r_g;
    logic [3:0]  r_cnt;
    logic [15:0] r_res;

    logic        w_any_req;
    logic        w_grant;
    logic        w_accept;
    logic        w_rsp_hs;

    assign w_any_req = req0_valid | req1_valid;
    assign w_accept  = (r_state == S_IDLE) && w_any_req;
    assign w_rsp_hs  = (r_state == S_RESP) && (r_g ? rsp1_ready : rsp0_ready);

`ifdef DVSD_MUL_ARB_RR_EN
    logic r_last_grant;

    // On contention the port that did not win last time goes first.
    assign w_grant = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_grant;
        end
    end
`else
    assign w_grant = ~req0_valid;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req)      w_next_state = S_CALC;
            S_CALC:  if (r_cnt == 4'd0)  w_next_state = S_RESP;
            S_RESP:  if (w_rsp_hs)       w_next_state = S_IDLE;
            default:                     w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        req0_ready = w_accept && !w_grant;
        req1_ready = w_accept &&  w_grant;
        rsp0_valid = (r_state == S_RESP) && !r_g;
        rsp1_valid = (r_state == S_RESP) &&  r_g;
        rsp0_m     = rsp0_valid ? r_res : 16'd0;
        rsp1_m     = rsp1_valid ? r_res : 16'd0;
        mul_a      = r_op_a;
        mul_b      = r_op_b;
        busy       = (r_state != S_IDLE);
    end

    // Operands stay on the multiplier after capture so its inputs never glitch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_op_a <= 8'd0;
            r_op_b <= 8'd0;
            r_g    <= 1'b0;
            r_cnt  <= 4'd0;
            r_res  <= 16'd0;
        end else begin
            if (w_accept) begin
                r_op_a <= w_grant ? req1_a : req0_a;
                r_op_b <= w_grant ? req1_b : req0_b;
                r_g    <= w_grant;
                r_cnt  <= C_CNT_INIT;
            end else if (r_state == S_CALC) begin
                if (r_cnt == 4'd0) begin
                    r_res <= mul_m;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/dvsd_mul_arb.md
# dvsd_mul_arb

Two-port arbiter and sequencer for the shared 8x8 to 16-bit combinational multiplier `dvsd_8216m3`. It accepts operand requests from two independent requesters over valid/ready handshakes and grants one at a time. It holds the granted operands on the multiplier inputs for a programmable settle time, then captures the product and returns it on the granted requester's response channel. It sits between the requesters and a single `dvsd_8216m3` instance at the next level up.

## Interface
Parameters:
- `SETTLE_CYC`, default 1: cycles the operands are held on the multiplier before the product is captured. Legal range 1..15.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  requester n has operands pending.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  8 each  unsigned operands.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle.
- `rsp0_valid` / `rsp1_valid`  out  1  result available for requester n.
- `rsp0_m` / `rsp1_m`  out  16  product.
- `rsp0_ready` / `rsp1_ready`  in  1  requester n consumes the result.
- `mul_a`, `mul_b`  out  8 each  drive `dvsd_8216m3` ports `a` and `b`.
- `mul_m`  in  16  from `dvsd_8216m3` port `m`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, CALC, RESP.
- **IDLE**
  - If any `reqN_valid` is high, the arbiter selects a grant.
  - `reqG_ready` for the granted port is combinationally high in that cycle.
  - On the edge: latch the operands into `op_a`/`op_b`, latch the grant index `g`, load the settle counter with `SETTLE_CYC-1`, and go to CALC.
  - The ungranted port's ready stays low. Its request is not dropped; the requester must hold it.
- **CALC**
  - `mul_a`/`mul_b` are driven from `op_a`/`op_b`.
  - The counter decrements each cycle.
  - On the edge where the counter is 0: capture `mul_m` into `res`, then go to RESP.
- **RESP**
  - `rspG_valid` is high and `rspG_m = res`. Both are held stable until `rspG_ready` is high.
  - On the handshake edge, return to IDLE.
  - The other port's `rsp_valid` is 0 and its `rsp_m` is 0.
- Outside CALC, `mul_a`/`mul_b` still reflect `op_a`/`op_b` (no glitch to zero). Only the capture in CALC is meaningful.
- Arithmetic:
  - Unsigned throughout; the 16-bit product never overflows (max 255*255 = 0xFE01).
  - No truncation or sign extension.
- Requests are not accepted in CALC or RESP. Both ready outputs are low there.

## Timing
- Reset values: all `reqN_ready` = 0, all `rspN_valid` = 0, `rspN_m` = 0, `mul_a` = `mul_b` = 0, `busy` = 0. FSM = IDLE, `last_grant` = 1.
- Reset is asynchronous and may occur mid-operation. An in-flight result is discarded and no response is issued. After release, the block starts in IDLE.
- Latency:
  - Accept at edge E.
  - CALC occupies `SETTLE_CYC` cycles.
  - `rsp_valid` rises after edge E+`SETTLE_CYC`+... exactly: the first cycle of RESP is the cycle after edge E+`SETTLE_CYC`.
  - With `rsp_ready` tied high, issue-to-issue spacing is `SETTLE_CYC`+2 cycles.
- `rspG_ready` high in the first RESP cycle gives zero extra stall.
- A requester dropping `req_valid` before being granted is legal. Nothing is latched.
- `rsp_ready` asserted while `rsp_valid` is low is ignored.

## Configuration
- Macro `DVSD_MUL_ARB_RR_EN`.
- Defined (round-robin):
  - When both requests are valid, grant the port not equal to `last_grant`.
  - With a single valid request, grant it.
  - `last_grant` updates on every accept.
  - Reset value 1 means port 0 wins the first contention.
- Undefined (fixed priority):
  - Port 0 always wins contention.
  - The `last_grant` register is not implemented.

## Test plan
- Reset held for 3 cycles, then released with no requests -> all outputs 0, `busy` = 0, FSM stays IDLE.
- req0 = (150,150), `SETTLE_CYC` = 1, `rsp0_ready` tied high -> `req0_ready` pulses one cycle. `rsp0_valid` goes high 2 cycles after acceptance with `rsp0_m` = 0x57E4. `rsp1_valid` stays 0.
- req1 = (255,255), `rsp1_ready` held low for 4 cycles -> `rsp1_m` = 0xFE01 held stable with `rsp1_valid` high for 4 cycles. Return to IDLE on the cycle after `rsp1_ready` goes high.
- Both ports valid continuously, req0 = (3,5), req1 = (7,9):
  - RR build: grants alternate 0,1,0,1 with products 0x000F and 0x003F.
  - Fixed build: req0 is granted every time and req1 is never granted.
- `SETTLE_CYC` = 4, req0 = (0x12,0x34) -> CALC lasts exactly 4 cycles and `rsp0_m` = 0x03A8.
- Assert `reset` during CALC of req0 = (10,10) -> no `rsp0_valid` ever appears for that request. After release, a new req0 = (2,2) returns 0x0004.
